// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3 codes,
// and the alignment check, lane extraction and store-merge functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Covers both misalignment and encodings that are illegal for the direction.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] addr,
                                            input logic       we);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr[0];
            F3_W:    bad = (addr != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lsu_extract(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  addr);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_BU:   res = {24'h0, b};
            F3_HU:   res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lsu_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr);
        logic [31:0] res;
        res = word;
        case (funct3)
            F3_B: res[{addr, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr[1]) res[31:16] = wdata[15:0];
                else         res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sign/zero-extended load extraction and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    assign load_data = lsu_extract(word, funct3, addr_lo);
    assign merged    = lsu_merge(word, wdata, funct3, addr_lo);

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only dmem: sub-word stores via read-modify-write.
// Optional performance counters are built when LSU_PERF_EN is defined.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [31:0]       dmem_wd,
    input  logic [31:0]       dmem_rd
`ifdef LSU_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic              rsp_hs;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign req_err = lsu_misaligned(req_funct3, req_addr[1:0], req_we);
    assign dmem_a  = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .word      (dmem_rd),
        .wdata     (wdata_q),
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        dmem_we   = 1'b0;
        dmem_wd   = 32'h0;
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_err)                            state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W)  state_d = ST_WRITE;
                    else                                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: begin
                dmem_we = 1'b1;
                dmem_wd = data_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = data_q;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // data_q carries the store word into WRITE, then the load result (or 0) into RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        data_q  <= (req_we && !req_err) ? req_wdata : 32'h0;
                    end
                end
                ST_READ:  data_q <= we_q ? merged : load_data;
                ST_WRITE: data_q <= 32'h0;
                ST_RESP: begin
                    if (rsp_hs) begin
                        data_q <= 32'h0;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads  <= 32'h0;
            perf_stores <= 32'h0;
            perf_errs   <= 32'h0;
        end else if (rsp_hs) begin
            if (err_q)     perf_errs   <= perf_errs + 32'd1;
            else if (we_q) perf_stores <= perf_stores + 32'd1;
            else           perf_loads  <= perf_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed LB/LH/LW/SB/SH/SW, errors, backpressure, reset mid-op.
module tb_lsu_rmw;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dmem_we;
    logic [31:0] dmem_a;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;
`ifdef LSU_PERF_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errs;
`endif

    lsu_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dmem_we    (dmem_we),
        .dmem_a     (dmem_a),
        .dmem_wd    (dmem_wd),
        .dmem_rd    (dmem_rd)
`ifdef LSU_PERF_EN
        ,
        .perf_loads (perf_loads),
        .perf_stores(perf_stores),
        .perf_errs  (perf_errs)
`endif
    );

    // Word-only dmem model: combinational read, synchronous write.
    logic [31:0] mem [0:63];
    assign dmem_rd = mem[dmem_a[7:2]];
    always @(posedge clk) if (dmem_we) mem[dmem_a[7:2]] <= dmem_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   we_cnt  = 0;
    bit   in_rsp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: latency on first rsp_valid, data/err/write-count on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() != 0 && dmem_we) we_cnt++;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!in_rsp) begin
                        in_rsp = 1;
                        check("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
                    end
                    if (rsp_ready) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("dmem_we_cycles", 32'(we_cnt), 32'(e.nwe));
                        we_cnt = 0;
                        in_rsp = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_nwe);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.nwe   = exp_nwe;
        e.acc   = cyc;
        sb_q.push_back(e);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEE0;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]     = 32'hAABBCCDD;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;

        #3;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_a", dmem_a, 32'h0);
        check("rst_outputs", {dmem_wd | rsp_rdata}, 32'h0);
`ifdef LSU_PERF_EN
        check("rst_perf", perf_loads | perf_stores | perf_errs, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1. word load
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'hAABBCCDD, 1'b0, 2, 0);
        // 2. sub-word loads
        issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0);
        issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000CCDD, 1'b0, 2, 0);
        // 3. byte RMW, then full word store
        issue(1'b1, F3_B, 32'h11, 32'h12345677, 32'h0, 1'b0, 3, 1);
        drain();
        check("mem_after_sb", mem[4], 32'hAABB77DD);
        issue(1'b1, F3_W, 32'h10, 32'h01020304, 32'h0, 1'b0, 2, 1);
        drain();
        check("mem_after_sw", mem[4], 32'h01020304);
        // 4. rejected requests
        issue(1'b1, F3_H, 32'h11, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        issue(1'b0, F3_W, 32'h12, 32'h0,        32'h0, 1'b1, 1, 0);
        issue(1'b0, 3'b011, 32'h10, 32'h0,      32'h0, 1'b1, 1, 0);
        drain();
        check("mem_after_err", mem[4], 32'h01020304);
`ifdef LSU_PERF_EN
        check("perf_loads", perf_loads, 32'd5);
        check("perf_stores", perf_stores, 32'd2);
        check("perf_errs", perf_errs, 32'd3);
`endif

        // 5. response backpressure, then back-to-back request
        rsp_ready = 1'b0;
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'h01020304, 1'b0, 2, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'h01020304);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("idle_after_hs_ready", 32'(req_ready), 32'd1);
        check("idle_after_hs_valid", 32'(rsp_valid), 32'd0);
        issue(1'b0, F3_B, 32'h13, 32'h0, 32'h00000001, 1'b0, 2, 0);
        drain();

        // 6. reset during the READ of a byte store
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = F3_B;
        req_addr   = 32'h12;
        req_wdata  = 32'h00000055;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_dmem_we", 32'(dmem_we), 32'd0);
        check("midrst_dmem_wd", dmem_wd, 32'h0);
        check("midrst_dmem_a", dmem_a, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mem_after_rst", mem[4], 32'h01020304);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'h01020304, 1'b0, 2, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
